parking_gate_arbiter: RTL and testbench
=======================================

Name: parking_gate_arbiter

Overview:
- Shares one parking lot's capacity between NUM_GATES entrance barriers.
- Grants one entrance at a time in round-robin order and holds that barrier open for a fixed time.
- Tracks lot occupancy from grants and exit events; blocks new entries when the lot is full.
- Sits between the per-gate sensor/password front ends and the barrier and LED drivers.

Parameters:
NUM_GATES, 4, number of entrance gates (2..8)
CAPACITY, 15, maximum cars in the lot (1..2^COUNT_W-1)
COUNT_W, 4, width of the occupancy counter
OPEN_CYCLES, 8, cycles the granted barrier stays open (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous reset, active-high
entry_req  input  NUM_GATES  level per gate; high = car at entrance with a validated password
exit_evt  input  NUM_GATES  single-cycle pulse per exit lane when a car leaves
gate_open  output  NUM_GATES  one-hot or zero; opens the barrier of the granted gate
busy  output  1  high in any state other than IDLE
full  output  1  high when occupancy == CAPACITY
occupancy  output  COUNT_W  registered car count
err_underflow  output  1  sticky flag: exit event seen while occupancy was 0

Behaviour:
- Reset (clk edge with reset=1):
  - gate_open=0, busy=0, occupancy=0, full=0, err_underflow=0.
  - FSM goes to IDLE.
  - RR pointer is set to NUM_GATES-1, so gate 0 has top priority next.
  - Reset mid-operation aborts any grant immediately: gate_open drops on that edge, and no occupancy change is applied.
- FSM states: IDLE, HOLD, CLEAR.
- IDLE:
  - If any entry_req bit is set and registered occupancy < CAPACITY, select the first requesting gate scanning from ptr+1 upward, with wrap-around.
  - On that edge: grant_idx <= selected gate, ptr <= selected gate, gate_open[grant_idx] <= 1, timer <= OPEN_CYCLES-1, entry increment applied, state -> HOLD.
  - If full, no grant is made and requests stay pending. No request is lost; the gate simply waits.
- HOLD:
  - gate_open[grant_idx]=1.
  - Timer decrements each cycle. When timer==0, on the next edge: gate_open <= 0, state -> CLEAR.
  - gate_open is therefore high for exactly OPEN_CYCLES cycles.
- CLEAR:
  - Wait until entry_req[grant_idx]==0, i.e. the car has left the entrance sensor; then state -> IDLE.
  - This prevents one car from being counted twice.
  - Other gates' requests are not served in HOLD or CLEAR.
- Latency: the request is sampled at edge N, and gate_open is visible after edge N (the same edge that registers the grant). The earliest next grant comes 1 cycle after CLEAR exits.
- Occupancy update, every edge:
  - occupancy <= occupancy + inc - dec.
  - inc = 1 on the grant edge, else 0.
  - dec = popcount(exit_evt).
  - Arithmetic uses COUNT_W+1 bits internally.
- Simultaneous grant and exits: both apply in the same edge (net change). The grant eligibility check uses registered occupancy before the update, so an exit in the same cycle does not unblock a grant when the lot is full.
- Underflow: if dec exceeds occupancy+inc, occupancy saturates at 0 and err_underflow <= 1. err_underflow is cleared only by reset.
- Overflow is impossible by construction, because grants are only made when occupancy < CAPACITY.
- full and busy are combinational from registered state (occupancy and FSM).
- entry_req bits of non-granted gates may toggle freely; only the granted gate's bit is observed in CLEAR.

Test Plan:
- Reset then single request: entry_req=0001 at cycle 3 -> gate_open=0001 for exactly 8 cycles, occupancy 0->1 on the grant edge, busy high until entry_req[0] drops, then IDLE.
- Round-robin: entry_req=1111 held, each request dropped after its gate closes -> grant order 0,1,2,3, then 0 again when re-requested; never two gate_open bits at once; occupancy reaches 4.
- Full: preload 15 grants -> full=1, entry_req=0100 gives no gate_open; an exit_evt pulse on lane 1 -> occupancy 14, full=0, and gate 2 is granted on the following edge (not the same one).
- Simultaneous events: occupancy=5, grant edge coincides with exit_evt=0011 -> occupancy 4 after the edge.
- Underflow: occupancy=1, exit_evt=0110 -> occupancy 0 and err_underflow=1; it stays 1 through later traffic until reset.
- Mid-operation reset: assert reset during HOLD with timer=4 -> on the next edge gate_open=0, occupancy=0, FSM=IDLE; after release, gate 0 wins when entry_req=1001.

Source files
------------

// File: rtl/parking_gate_arbiter.sv
// Round-robin entrance arbiter for a shared parking lot: grants one barrier at
// a time, holds it open for a fixed time and tracks lot occupancy.
module parking_gate_arbiter #(
  parameter int NUM_GATES   = 4,
  parameter int CAPACITY    = 15,
  parameter int COUNT_W     = 4,
  parameter int OPEN_CYCLES = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NUM_GATES-1:0] i_entry_req,
  input  logic [NUM_GATES-1:0] i_exit_evt,
  output logic [NUM_GATES-1:0] o_gate_open,
  output logic                 o_busy,
  output logic                 o_full,
  output logic [COUNT_W-1:0]   o_occupancy,
  output logic                 o_err_underflow
);

  localparam int PW = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
  localparam int TW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
  localparam int DW = $clog2(NUM_GATES + 1);
  localparam int AW = (COUNT_W + 1 > DW) ? COUNT_W + 1 : DW;

  localparam logic [COUNT_W-1:0] CAP_C     = COUNT_W'(CAPACITY);
  localparam logic [TW-1:0]      TLOAD_C   = TW'(OPEN_CYCLES - 1);
  localparam logic [PW-1:0]      PTR_RST_C = PW'(NUM_GATES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_grant_idx;
  logic [TW-1:0]       r_timer;
  logic [COUNT_W-1:0]  r_occupancy;
  logic                r_err_underflow;

  logic                w_found;
  logic [PW-1:0]       w_sel;
  logic                w_grant;
  logic [AW-1:0]       w_sum;
  logic [AW-1:0]       w_dec;

  // Scan requests starting just above the last winner, wrapping around.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 1; k <= NUM_GATES; k++) begin
      idx = (int'(r_ptr) + k) % NUM_GATES;
      if (!w_found && i_entry_req[PW'(idx)]) begin
        w_found = 1'b1;
        w_sel   = PW'(idx);
      end
    end
  end

  assign w_grant = (r_state == IDLE) && w_found && (r_occupancy < CAP_C);

  always_comb begin
    w_dec = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      w_dec = w_dec + AW'(i_exit_evt[i]);
    end
    w_sum = AW'(r_occupancy) + AW'(w_grant);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next_state = HOLD;
      HOLD:    if (r_timer == '0) w_next_state = CLEAR;
      CLEAR:   if (!i_entry_req[r_grant_idx]) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    o_gate_open = '0;
    if (r_state == HOLD) begin
      o_gate_open = NUM_GATES'(1) << r_grant_idx;
    end
    o_busy = (r_state != IDLE);
    o_full = (r_occupancy == CAP_C);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr       <= PTR_RST_C;
      r_grant_idx <= '0;
      r_timer     <= '0;
    end else if (w_grant) begin
      r_ptr       <= w_sel;
      r_grant_idx <= w_sel;
      r_timer     <= TLOAD_C;
    end else if (r_state == HOLD && r_timer != '0) begin
      r_timer <= r_timer - 1'b1;
    end
  end

  // More exits than cars saturates at zero and latches the error until reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_occupancy     <= '0;
      r_err_underflow <= 1'b0;
    end else if (w_dec > w_sum) begin
      r_occupancy     <= '0;
      r_err_underflow <= 1'b1;
    end else begin
      r_occupancy <= COUNT_W'(w_sum - w_dec);
    end
  end

  assign o_occupancy     = r_occupancy;
  assign o_err_underflow = r_err_underflow;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter: reset, single grant, round-robin,
// full lot, simultaneous events, underflow and mid-operation reset.
module tb_parking_gate_arbiter;

  localparam int NG = 4;

  logic          clk;
  logic          reset;
  logic [NG-1:0] entry_req;
  logic [NG-1:0] exit_evt;
  logic [NG-1:0] gate_open;
  logic          busy;
  logic          full;
  logic [3:0]    occupancy;
  logic          err_underflow;

  int nvec;
  int nfail;

  parking_gate_arbiter #(
    .NUM_GATES(4), .CAPACITY(15), .COUNT_W(4), .OPEN_CYCLES(8)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_entry_req(entry_req),
    .i_exit_evt(exit_evt),
    .o_gate_open(gate_open),
    .o_busy(busy),
    .o_full(full),
    .o_occupancy(occupancy),
    .o_err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  // Stimulus only: from the grant edge, run out the hold, then release gate g.
  task automatic finish_grant(input int g);
    step(8);
    entry_req[g] = 1'b0;
    step(1);
  endtask

  task automatic grant_n(input int n);
    for (int i = 0; i < n; i++) begin
      entry_req = 4'b0001;
      step(1);
      finish_grant(0);
    end
  endtask

  task automatic test_reset();
    entry_req = '0;
    exit_evt  = '0;
    do_reset();
    nvec++;
    if (gate_open !== 4'b0000 || busy !== 1'b0 || full !== 1'b0 ||
        occupancy !== 4'd0 || err_underflow !== 1'b0) begin
      nfail++;
      $display("[TB] FAIL reset: gate_open=%b busy=%b full=%b occ=%0d err=%b, want 0000 0 0 0 0",
               gate_open, busy, full, occupancy, err_underflow);
    end
  endtask

  task automatic test_single();
    int cnt;
    do_reset();
    step(3);
    entry_req = 4'b0001;
    step(1);
    nvec++;
    if (gate_open !== 4'b0001 || occupancy !== 4'd1 || busy !== 1'b1) begin
      nfail++;
      $display("[TB] FAIL single_grant: gate_open=%b occ=%0d busy=%b, want 0001 1 1",
               gate_open, occupancy, busy);
    end
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (gate_open === 4'b0001) cnt++;
      else break;
    end
    nvec++;
    if (cnt != 8) begin
      nfail++;
      $display("[TB] FAIL open_length: %0d cycles, want 8", cnt);
    end
    nvec++;
    if (busy !== 1'b1 || gate_open !== 4'b0000) begin
      nfail++;
      $display("[TB] FAIL clear_wait: busy=%b gate_open=%b, want 1 0000", busy, gate_open);
    end
    step(2);
    nvec++;
    if (busy !== 1'b1) begin
      nfail++;
      $display("[TB] FAIL clear_hold: busy=%b, want 1", busy);
    end
    entry_req = 4'b0000;
    step(1);
    nvec++;
    if (busy !== 1'b0 || occupancy !== 4'd1) begin
      nfail++;
      $display("[TB] FAIL back_idle: busy=%b occ=%0d, want 0 1", busy, occupancy);
    end
  endtask

  task automatic test_round_robin();
    logic [NG-1:0] want;
    do_reset();
    entry_req = 4'b1111;
    for (int g = 0; g < NG; g++) begin
      want = 4'b0001 << g;
      step(1);
      nvec++;
      if (gate_open !== want || occupancy !== 4'(g + 1)) begin
        nfail++;
        $display("[TB] FAIL rr_grant%0d: gate_open=%b occ=%0d, want %b %0d",
                 g, gate_open, occupancy, want, g + 1);
      end
      for (int c = 0; c < 7; c++) begin
        step(1);
        nvec++;
        if (gate_open !== want) begin
          nfail++;
          $display("[TB] FAIL rr_hold%0d: gate_open=%b, want %b", g, gate_open, want);
        end
      end
      step(1);
      nvec++;
      if (gate_open !== 4'b0000 || busy !== 1'b1) begin
        nfail++;
        $display("[TB] FAIL rr_clear%0d: gate_open=%b busy=%b, want 0000 1", g, gate_open, busy);
      end
      entry_req[g] = 1'b0;
      step(1);
      nvec++;
      if (busy !== 1'b0) begin
        nfail++;
        $display("[TB] FAIL rr_idle%0d: busy=%b, want 0", g, busy);
      end
    end
    entry_req = 4'b0001;
    step(1);
    nvec++;
    if (gate_open !== 4'b0001 || occupancy !== 4'd5) begin
      nfail++;
      $display("[TB] FAIL rr_wrap: gate_open=%b occ=%0d, want 0001 5", gate_open, occupancy);
    end
    finish_grant(0);
  endtask

  task automatic test_full();
    do_reset();
    grant_n(15);
    nvec++;
    if (occupancy !== 4'd15 || full !== 1'b1) begin
      nfail++;
      $display("[TB] FAIL full_flag: occ=%0d full=%b, want 15 1", occupancy, full);
    end
    entry_req = 4'b0100;
    step(3);
    nvec++;
    if (gate_open !== 4'b0000 || busy !== 1'b0) begin
      nfail++;
      $display("[TB] FAIL full_block: gate_open=%b busy=%b, want 0000 0", gate_open, busy);
    end
    exit_evt = 4'b0010;
    step(1);
    exit_evt = 4'b0000;
    nvec++;
    if (occupancy !== 4'd14 || full !== 1'b0 || gate_open !== 4'b0000) begin
      nfail++;
      $display("[TB] FAIL full_exit: occ=%0d full=%b gate_open=%b, want 14 0 0000",
               occupancy, full, gate_open);
    end
    step(1);
    nvec++;
    if (gate_open !== 4'b0100 || occupancy !== 4'd15) begin
      nfail++;
      $display("[TB] FAIL full_regrant: gate_open=%b occ=%0d, want 0100 15", gate_open, occupancy);
    end
    finish_grant(2);
  endtask

  task automatic test_simultaneous();
    do_reset();
    grant_n(5);
    entry_req = 4'b0001;
    exit_evt  = 4'b0011;
    step(1);
    exit_evt = 4'b0000;
    nvec++;
    if (occupancy !== 4'd4 || gate_open !== 4'b0001) begin
      nfail++;
      $display("[TB] FAIL simultaneous: occ=%0d gate_open=%b, want 4 0001", occupancy, gate_open);
    end
    finish_grant(0);
  endtask

  task automatic test_underflow();
    do_reset();
    grant_n(1);
    exit_evt = 4'b0110;
    step(1);
    exit_evt = 4'b0000;
    nvec++;
    if (occupancy !== 4'd0 || err_underflow !== 1'b1) begin
      nfail++;
      $display("[TB] FAIL underflow: occ=%0d err=%b, want 0 1", occupancy, err_underflow);
    end
    entry_req = 4'b0010;
    step(1);
    nvec++;
    if (occupancy !== 4'd1 || err_underflow !== 1'b1 || gate_open !== 4'b0010) begin
      nfail++;
      $display("[TB] FAIL underflow_sticky: occ=%0d err=%b gate_open=%b, want 1 1 0010",
               occupancy, err_underflow, gate_open);
    end
    finish_grant(1);
    do_reset();
    nvec++;
    if (err_underflow !== 1'b0) begin
      nfail++;
      $display("[TB] FAIL underflow_clear: err=%b, want 0", err_underflow);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    entry_req = 4'b0010;
    step(1);
    step(3);
    nvec++;
    if (gate_open !== 4'b0010 || occupancy !== 4'd1) begin
      nfail++;
      $display("[TB] FAIL midreset_pre: gate_open=%b occ=%0d, want 0010 1", gate_open, occupancy);
    end
    reset = 1'b1;
    step(1);
    nvec++;
    if (gate_open !== 4'b0000 || occupancy !== 4'd0 || busy !== 1'b0) begin
      nfail++;
      $display("[TB] FAIL midreset_abort: gate_open=%b occ=%0d busy=%b, want 0000 0 0",
               gate_open, occupancy, busy);
    end
    reset = 1'b0;
    entry_req = 4'b1001;
    step(1);
    nvec++;
    if (gate_open !== 4'b0001 || occupancy !== 4'd1) begin
      nfail++;
      $display("[TB] FAIL midreset_prio: gate_open=%b occ=%0d, want 0001 1", gate_open, occupancy);
    end
    finish_grant(0);
    entry_req = 4'b0000;
    step(2);
  endtask

  initial begin
    nvec      = 0;
    nfail     = 0;
    reset     = 1'b1;
    entry_req = '0;
    exit_evt  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_simultaneous();
    test_underflow();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
